circuit2_fsmd: RTL

- Scheduled, multi-cycle FSM-with-datapath implementation of the circuit2 dataflow graph.
- A single shared add/sub ALU and one comparator are time-multiplexed across the d/e/f/compare/select/shift operations under a fixed schedule.
- Start/Done handshake; sits as a leaf compute unit driven by a host sequencer.
- Output ports hold the last completed result while a new computation runs.

---
 rtl/circuit2_fsmd_pkg.sv | 20 ++
 rtl/circuit2_fsmd_alu_addsub.sv | 15 +
 rtl/circuit2_fsmd.sv | 115 +++++++++++
 3 files changed

// File: rtl/circuit2_fsmd_pkg.sv
// Shared definitions for the circuit2 FSMD: schedule states and ALU op codes.
package circuit2_fsmd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        S4    = 3'd4,
        S5    = 3'd5,
        S6    = 3'd6,
        FINAL = 3'd7
    } state_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } aluOp_t;

endpackage

// File: rtl/circuit2_fsmd_alu_addsub.sv
// Shared combinational add/sub unit; carry and borrow are dropped.
module alu_addsub
    import circuit2_fsmd_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  aluOp_t               op,
    input  logic [DATAWIDTH-1:0] p,
    input  logic [DATAWIDTH-1:0] q,
    output logic [DATAWIDTH-1:0] r
);

    assign r = (op == ALU_SUB) ? (p - q) : (p + q);

endmodule

// File: rtl/circuit2_fsmd.sv
// Scheduled FSMD for circuit2: one shared add/sub ALU, one comparator, Start/Done handshake.
// Output ports hold the previous result until the S6->FINAL edge of the next run.
module circuit2_fsmd
    import circuit2_fsmd_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 Busy,
    output logic                 Done,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z,
    output logic [DATAWIDTH-1:0] g,
    output logic [DATAWIDTH-1:0] h,
    output logic                 dLTe,
    output logic                 dEQe
);

    state_t               r_state;
    state_t               w_nextState;
    aluOp_t               w_aluOp;
    logic [DATAWIDTH-1:0] w_aluQ;
    logic [DATAWIDTH-1:0] w_aluR;

    logic [DATAWIDTH-1:0] r_ra, r_rb, r_rc;
    logic [DATAWIDTH-1:0] r_d, r_e, r_f, r_g, r_h, r_x;
    logic                 r_lt, r_eq;

    alu_addsub #(.DATAWIDTH(DATAWIDTH)) u_alu (
        .op (w_aluOp),
        .p  (r_ra),
        .q  (w_aluQ),
        .r  (w_aluR)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    // The first ALU operand is always ra; only the second operand and op depend on state.
    always_comb begin
        w_nextState = r_state;
        w_aluOp     = ALU_ADD;
        w_aluQ      = r_rb;
        case (r_state)
            IDLE:    if (Start) w_nextState = S1;
            S1:      w_nextState = S2;
            S2: begin
                w_nextState = S3;
                w_aluQ      = r_rc;
            end
            S3: begin
                w_nextState = S4;
                w_aluOp     = ALU_SUB;
            end
            S4:      w_nextState = S5;
            S5:      w_nextState = S6;
            S6:      w_nextState = FINAL;
            FINAL:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign Busy = (r_state != IDLE);

    // z is published straight from the shifter since it is produced on the same edge.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_ra <= '0; r_rb <= '0; r_rc <= '0;
            r_d  <= '0; r_e  <= '0; r_f  <= '0;
            r_g  <= '0; r_h  <= '0; r_x  <= '0;
            r_lt <= 1'b0; r_eq <= 1'b0;
            x    <= '0; z    <= '0; g    <= '0; h <= '0;
            dLTe <= 1'b0; dEQe <= 1'b0;
            Done <= 1'b0;
        end else begin
            Done <= (r_state == S6);
            case (r_state)
                IDLE: if (Start) begin
                    r_ra <= a;
                    r_rb <= b;
                    r_rc <= c;
                end
                S1: r_d <= w_aluR;
                S2: r_e <= w_aluR;
                S3: begin
                    r_f  <= w_aluR;
                    r_lt <= (r_d < r_e);
                    r_eq <= (r_d == r_e);
                end
                S4: r_g <= r_lt ? r_d : r_e;
                S5: begin
                    r_h <= r_eq ? r_g : r_f;
                    r_x <= r_g << r_lt;
                end
                S6: begin
                    x    <= r_x;
                    z    <= r_h >> r_eq;
                    g    <= r_g;
                    h    <= r_h;
                    dLTe <= r_lt;
                    dEQe <= r_eq;
                end
                default: ;
            endcase
        end
    end

endmodule
